// File: rtl/soc_sram_responder.sv
// Shared-RAM responder for an instruction and a data port. Data addresses in the MMIO page
// reach LED, TIMER, SWITCH and SCRATCH registers. All reads return data one cycle later.
module soc_sram_responder #(
  parameter int unsigned MEM_AW  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  localparam int unsigned Words = 2 ** MEM_AW;

  logic [31:0] mem [Words];

  logic [MEM_AW-1:0] inst_idx;
  logic [MEM_AW-1:0] data_idx;
  logic              data_mmio;
  logic [15:0]       mmio_off;
  logic [31:0]       mmio_rdata;
  logic              data_wr;
  logic [15:0]       led_q;
  logic [31:0]       timer_q;
  logic [31:0]       scratch_q;
  logic              unused_bits;

  // The instruction port never sees MMIO: its upper address bits simply alias into RAM.
  assign inst_idx  = inst_sram_addr[MEM_AW+1:2];
  assign data_idx  = data_sram_addr[MEM_AW+1:2];
  assign data_mmio = (data_sram_addr[31:16] == MMIO_HI);
  assign mmio_off  = data_sram_addr[15:0];
  assign data_wr   = data_sram_en && (data_sram_we != 4'h0) && !reset;
  assign led_out   = led_q;

  assign unused_bits = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr, data_sram_addr};

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      16'h0000: mmio_rdata = {16'h0, led_q};
      16'h0004: mmio_rdata = timer_q;
      16'h0008: mmio_rdata = {16'h0, switch_in};
      16'h000C: mmio_rdata = scratch_q;
      default:  mmio_rdata = 32'h0;
    endcase
  end

  // RAM contents survive reset; only writes presented during reset are blocked.
  always_ff @(posedge clk) begin
    if (data_wr && !data_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) mem[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
      led_q           <= 16'h0;
      timer_q         <= 32'h0;
      scratch_q       <= 32'h0;
    end else begin
      if (inst_sram_en) inst_sram_rdata <= mem[inst_idx];
      if (data_sram_en) data_sram_rdata <= data_mmio ? mmio_rdata : mem[data_idx];

      if (data_wr && data_mmio && mmio_off == 16'h0004 && data_sram_we == 4'hF) begin
        timer_q <= data_sram_wdata;
      end else begin
        timer_q <= timer_q + 32'd1;
      end

      if (data_wr && data_mmio && mmio_off == 16'h0000) begin
        if (data_sram_we[0]) led_q[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_we[1]) led_q[15:8] <= data_sram_wdata[15:8];
      end

      if (data_wr && data_mmio && mmio_off == 16'h000C) begin
        for (int b = 0; b < 4; b++) begin
          if (data_sram_we[b]) scratch_q[8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/soc_sram_responder.md
SOC_SRAM_RESPONDER -- requirements
Module: soc_sram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, word-address width of the shared RAM (2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter MMIO_HI, default 16'hBFAF, value of addr[31:16] that selects the MMIO region.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inst_sram_en  input  1  instruction fetch request.
REQ-006 SHALL have port inst_sram_we  input  4  instruction-port byte write enables; ignored.
REQ-007 SHALL have port inst_sram_addr  input  32  fetch byte address.
REQ-008 SHALL have port inst_sram_wdata  input  32  ignored.
REQ-009 SHALL have port inst_sram_rdata  output  32  fetch data.
REQ-010 SHALL have port data_sram_en  input  1  data access request.
REQ-011 SHALL have port data_sram_we  input  4  byte write enables; 4'h0 means read.
REQ-012 SHALL have port data_sram_addr  input  32  data byte address.
REQ-013 SHALL have port data_sram_wdata  input  32  store data, byte lanes aligned to the address.
REQ-014 SHALL have port data_sram_rdata  output  32  load data.
REQ-015 SHALL have port switch_in  input  16  board switch levels.
REQ-016 SHALL have port led_out  output  16  LED register value.

Function
REQ-017 SHALL implement one RAM array shared by both ports, indexed by addr[MEM_AW+1:2]; higher address bits outside the MMIO region SHALL be ignored (aliasing/wrap-around).
REQ-018 SHALL, for an instruction request (inst_sram_en=1) in cycle N, present the addressed word on inst_sram_rdata in cycle N+1 (latency exactly 1, no stall).
REQ-019 SHALL, for a data read (en=1, we=0) in cycle N, present the addressed word on data_sram_rdata in cycle N+1.
REQ-020 SHALL, for a data write (en=1, we!=0), update only the bytes whose we bit is 1 at the posedge ending cycle N; data_sram_rdata in N+1 SHALL show the pre-write word (read-first).
REQ-021 SHALL, when instruction and data ports hit the same word in one cycle with a data write, return the pre-write word on inst_sram_rdata.
REQ-022 SHALL hold each rdata output at its last value in any cycle following en=0.
REQ-023 SHALL decode data addresses with addr[31:16]==MMIO_HI as MMIO: no RAM access, offsets addr[15:0]: 0x0000 LED, 0x0004 TIMER, 0x0008 SWITCH, 0x000C SCRATCH.
REQ-024 SHALL implement LED as 16-bit R/W; we[0] writes bits 7:0, we[1] bits 15:8; upper read bits zero; led_out = LED register.
REQ-025 SHALL implement TIMER as 32-bit counter incrementing by 1 every non-reset cycle, wrapping 32'hFFFF_FFFF->0; a write with we=4'hF SHALL load wdata (write wins over increment); partial-byte writes SHALL be ignored.
REQ-026 SHALL return the TIMER value sampled in the request cycle N.
REQ-027 SHALL implement SWITCH as read-only {16'h0, switch_in sampled in cycle N}; writes ignored.
REQ-028 SHALL implement SCRATCH as 32-bit register with per-byte write enables.
REQ-029 SHALL return 32'h0 for reads of unmapped MMIO offsets and ignore writes to them.
REQ-030 SHALL ignore instruction-port addresses in the MMIO region only by mapping them to RAM (instruction port never accesses MMIO).

Reset
REQ-031 SHALL, while reset=1, drive both rdata registers, LED, TIMER and SCRATCH to 0 on the next posedge; RAM contents SHALL NOT be reset.
REQ-032 SHALL ignore any request presented in a cycle with reset=1 (no RAM/MMIO write; rdata 0 next cycle).
REQ-033 SHALL have TIMER read 0 in the first cycle after reset deasserts, 1 in the next.

Verification
REQ-034 Data write 0x1C00_0010 we=4'hF wdata=32'hDEAD_BEEF, then read same address -> data_sram_rdata=32'hDEAD_BEEF one cycle after the read; inst fetch of 0x1C00_0010 -> same value.
REQ-035 Byte write we=4'b0010 wdata=32'h0000_AB00 over 32'h1122_3344 -> next read 32'h1122_AB44; same-cycle read of write -> 32'h1122_3344.
REQ-036 Write TIMER (0xBFAF_0004) 32'hFFFF_FFFE we=4'hF, read next cycle -> 32'hFFFF_FFFE, read following cycle -> 32'hFFFF_FFFF, then 32'h0 (wrap); we=4'h1 write -> no load.
REQ-037 Write LED 32'h1234_5678 we=4'hF -> led_out=16'h5678, LED read 32'h0000_5678; switch_in=16'hA5A5 -> SWITCH read 32'h0000_A5A5; read 0xBFAF_0100 -> 0.
REQ-038 Assert reset for 1 cycle with a pending write to SCRATCH -> SCRATCH reads 0, LED 0, rdata 0, RAM word written before reset retained.
REQ-039 Address aliasing: write 0x0000_0008 value 32'h5, read 0x0000_4008 (MEM_AW=12) -> 32'h5.
